// File: rtl/ext_pkg.sv
// ext_pkg: shared definitions for the intra neighbour extractor.
//   - output tag codes carried alongside each pixel beat
//   - blk_size request codes and the size -> N / log2(N) lookups
//   - extractor FSM state type
//   - neutral (mid-grey) pixel value helper
package ext_pkg;

  localparam logic [1:0] TAG_BLK     = 2'd0;
  localparam logic [1:0] TAG_TOP     = 2'd1;
  localparam logic [1:0] TAG_LEFT    = 2'd2;
  localparam logic [1:0] TAG_TOPLEFT = 2'd3;

  localparam logic [1:0] SIZE_4   = 2'd0;
  localparam logic [1:0] SIZE_8   = 2'd1;
  localparam logic [1:0] SIZE_16  = 2'd2;
  localparam logic [1:0] SIZE_BAD = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TL,
    S_TOP,
    S_LEFT,
    S_BLK,
    S_DRAIN
  } ext_state_t;

  function automatic logic [4:0] size_to_n(input logic [1:0] s);
    case (s)
      SIZE_4:  return 5'd4;
      SIZE_8:  return 5'd8;
      SIZE_16: return 5'd16;
      default: return 5'd0;
    endcase
  endfunction

  function automatic logic [2:0] size_to_lg(input logic [1:0] s);
    case (s)
      SIZE_4:  return 3'd2;
      SIZE_8:  return 3'd3;
      SIZE_16: return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

  // Neutral value used for unavailable neighbours: 1 << (pix_w-1).
  function automatic int unsigned neutral_value(input int unsigned pix_w);
    return 32'd1 << (pix_w - 1);
  endfunction

endpackage

// File: rtl/ext_out_fifo.sv
// ext_out_fifo: 2-entry output FIFO for tagged pixel beats.
// Ports:
//   clk, reset   clock / asynchronous active-high reset (flushes contents)
//   push, din    write one entry (caller guarantees it is never full on push)
//   pop          remove head entry (caller guarantees it is never empty on pop)
//   dout         head entry, held stable until popped
//   count        current occupancy 0..2
module ext_out_fifo #(
  parameter int W = 11
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic [1:0]   count
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign dout = mem[rd_ptr];

endmodule

// File: rtl/intra_neighbour_extractor.sv
// intra_neighbour_extractor: on start, fetches an NxN block (N=4/8/16) plus its
// top-left, top (and optionally top-right) and left neighbours from the
// reconstructed-frame memory and streams them out as tagged valid/ready beats.
// Beat order: TOPLEFT, TOP[0..T-1], LEFT[0..N-1], BLK row-major.
// Ports:
//   clk, reset              clock / asynchronous active-high reset
//   start, blk_size,        request (sampled in IDLE only); blk_size 3 = illegal
//   blk_x, blk_y
//   busy, err               job in progress / 1-cycle reject pulse
//   mem_rd_en, mem_rd_addr  read strobe and y*FRAME_W+x address
//   mem_rd_data             read data, valid the cycle after mem_rd_en
//   o_valid, o_ready        output handshake
//   o_data, o_tag, o_last   pixel, tag (ext_pkg TAG_*), final beat marker
// Configuration macro: EXTRACT_TOPRIGHT_EN -> T=2N with top-right replication
// past the frame edge; undefined -> T=N.
module intra_neighbour_extractor
  import ext_pkg::*;
#(
  parameter int FRAME_W = 256,
  parameter int FRAME_H = 256,
  parameter int PIX_W   = 8,
  parameter int ADDR_W  = $clog2(FRAME_W * FRAME_H)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        blk_size,
  input  logic [15:0]       blk_x,
  input  logic [15:0]       blk_y,
  output logic              busy,
  output logic              err,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [PIX_W-1:0]  mem_rd_data,
  output logic              o_valid,
  input  logic              o_ready,
  output logic [PIX_W-1:0]  o_data,
  output logic [1:0]        o_tag,
  output logic              o_last
);

  localparam int                EW      = PIX_W + 3;
  localparam logic [PIX_W-1:0]  NEUTRAL = PIX_W'(neutral_value(PIX_W));
  localparam logic [ADDR_W-1:0] FW_A    = ADDR_W'(FRAME_W);
  localparam logic [ADDR_W-1:0] ONE_A   = ADDR_W'(1);

  ext_state_t        state;
  ext_state_t        adv_state;
  logic [ADDR_W-1:0] x_r, y_r;
  logic [4:0]        n_r;
  logic [2:0]        lg_r;
  logic [8:0]        cnt;
  logic              pend;
  logic              pend_last;
  logic [1:0]        pend_tag;
`ifdef EXTRACT_TOPRIGHT_EN
  logic [PIX_W-1:0]  rep_r;
`endif

  logic [4:0]        n_in;
  logic [15:0]       align_mask;
  logic              start_ok;

  logic [ADDR_W-1:0] cnt_a, px, py;
  logic [5:0]        t_len;
  logic [8:0]        last_idx;
  logic              synth, gen_state, gen, at_end, beat_last, pop, push;
  logic [1:0]        cur_tag, fifo_count;
  logic [PIX_W-1:0]  syn_data;
  logic [2:0]        occ;
  logic [EW-1:0]     fifo_din, fifo_dout;

  always_comb begin
    n_in       = size_to_n(blk_size);
    align_mask = 16'(n_in - 5'd1);
    start_ok   = (blk_size != SIZE_BAD) &&
                 ((blk_x & align_mask) == '0) && ((blk_y & align_mask) == '0) &&
                 (32'(blk_x) < FRAME_W) && (32'(blk_y) < FRAME_H);
  end

`ifdef EXTRACT_TOPRIGHT_EN
  assign t_len = {n_r, 1'b0};
`else
  assign t_len = {1'b0, n_r};
`endif

  // Per-beat source selection and address generation for the current state.
  always_comb begin
    cnt_a     = ADDR_W'(cnt);
    px        = '0;
    py        = '0;
    synth     = 1'b0;
    syn_data  = NEUTRAL;
    cur_tag   = TAG_BLK;
    last_idx  = '0;
    gen_state = 1'b1;
    adv_state = S_IDLE;
    unique case (state)
      S_TL: begin
        px        = x_r - ONE_A;
        py        = y_r - ONE_A;
        synth     = (x_r == '0) || (y_r == '0);
        cur_tag   = TAG_TOPLEFT;
        adv_state = S_TOP;
      end
      S_TOP: begin
        px        = x_r + cnt_a;
        py        = y_r - ONE_A;
        cur_tag   = TAG_TOP;
        last_idx  = 9'(t_len) - 9'd1;
        adv_state = S_LEFT;
`ifdef EXTRACT_TOPRIGHT_EN
        // Top-right beyond the frame edge repeats TOP[N-1] (held in rep_r).
        synth    = (y_r == '0) || ((cnt >= 9'(n_r)) && (px >= FW_A));
        syn_data = (y_r == '0) ? NEUTRAL : rep_r;
`else
        synth    = (y_r == '0);
`endif
      end
      S_LEFT: begin
        px        = x_r - ONE_A;
        py        = y_r + cnt_a;
        synth     = (x_r == '0);
        cur_tag   = TAG_LEFT;
        last_idx  = 9'(n_r) - 9'd1;
        adv_state = S_BLK;
      end
      S_BLK: begin
        px        = x_r + (cnt_a & (ADDR_W'(n_r) - ONE_A));
        py        = y_r + (cnt_a >> lg_r);
        last_idx  = (9'd1 << {lg_r, 1'b0}) - 9'd1;
        adv_state = S_DRAIN;
      end
      default: gen_state = 1'b0;
    endcase

    at_end    = (cnt == last_idx);
    beat_last = (state == S_BLK) && at_end;
    pop       = o_valid && o_ready;
    // Credit check counts the FIFO after this cycle's pop plus the read whose
    // data arrives this cycle; that keeps 1 beat/cycle with a 2-entry FIFO.
    occ       = 3'(fifo_count) + 3'(pend) - 3'(pop);
    // A synthesised beat must not overtake (or collide with) a returning read.
    gen       = gen_state && (occ < 3'd2) && !(synth && pend);
    push      = pend || (gen && synth);
    fifo_din  = pend ? {pend_last, pend_tag, mem_rd_data}
                     : {beat_last, cur_tag, syn_data};
    mem_rd_en   = gen && !synth;
    mem_rd_addr = py * FW_A + px;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      err       <= 1'b0;
      x_r       <= '0;
      y_r       <= '0;
      n_r       <= '0;
      lg_r      <= '0;
      cnt       <= '0;
      pend      <= 1'b0;
      pend_last <= 1'b0;
      pend_tag  <= '0;
`ifdef EXTRACT_TOPRIGHT_EN
      rep_r     <= '0;
`endif
    end else begin
      err       <= 1'b0;
      pend      <= mem_rd_en;
      pend_tag  <= cur_tag;
      pend_last <= beat_last;
`ifdef EXTRACT_TOPRIGHT_EN
      // Last TOP read to return is TOP[N-1] whenever replication is needed.
      if (pend && (pend_tag == TAG_TOP)) rep_r <= mem_rd_data;
`endif
      unique case (state)
        S_IDLE: begin
          if (start) begin
            if (start_ok) begin
              x_r   <= ADDR_W'(blk_x);
              y_r   <= ADDR_W'(blk_y);
              n_r   <= n_in;
              lg_r  <= size_to_lg(blk_size);
              cnt   <= '0;
              busy  <= 1'b1;
              state <= S_TL;
            end else begin
              err <= 1'b1;
            end
          end
        end
        S_TL, S_TOP, S_LEFT, S_BLK: begin
          if (gen) begin
            if (at_end) begin
              cnt   <= '0;
              state <= adv_state;
            end else begin
              cnt <= cnt + 9'd1;
            end
          end
        end
        S_DRAIN: begin
          if (pop && o_last) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  ext_out_fifo #(.W(EW)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (fifo_din),
    .pop   (pop),
    .dout  (fifo_dout),
    .count (fifo_count)
  );

  assign o_valid = (fifo_count != '0);
  assign o_data  = fifo_dout[PIX_W-1:0];
  assign o_tag   = fifo_dout[PIX_W+1:PIX_W];
  assign o_last  = fifo_dout[EW-1];

endmodule

// File: tb/tb_intra_neighbour_extractor.sv
module tb_intra_neighbour_extractor;
  localparam int W  = 256;
  localparam int H  = 256;
  localparam int PW = 8;
  localparam int AW = 16;
`ifdef EXTRACT_TOPRIGHT_EN
  localparam int TR = 2;
`else
  localparam int TR = 1;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [1:0]    blk_size;
  logic [15:0]   blk_x, blk_y;
  logic          busy, err, mem_rd_en;
  logic [AW-1:0] mem_rd_addr;
  logic [PW-1:0] mem_rd_data;
  logic          o_valid, o_ready;
  logic [PW-1:0] o_data;
  logic [1:0]    o_tag;
  logic          o_last;

  int checks   = 0;
  int failures = 0;

  logic [7:0]  mem [0:65535];
  logic [10:0] exp_q [$];
  int          exp_reads;

  always #5 clk = ~clk;

  // Memory model: data valid exactly one cycle after the read strobe.
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];

  intra_neighbour_extractor #(
    .FRAME_W(W), .FRAME_H(H), .PIX_W(PW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .blk_size(blk_size),
    .blk_x(blk_x), .blk_y(blk_y), .busy(busy), .err(err),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data), .o_tag(o_tag),
    .o_last(o_last)
  );

  task automatic fill_mem(input bit rnd);
    for (int a = 0; a < 65536; a++) mem[a] = rnd ? 8'($urandom) : 8'(a & 255);
  endtask

  function automatic logic [7:0] pix(input int x, input int y);
    return mem[y * W + x];
  endfunction

  // Reference: the expected beat list straight from the neighbour rules.
  task automatic build_expected(input int n, input int x, input int y);
    logic [7:0] v;
    logic [7:0] top_last;
    top_last = 8'h80;
    exp_q.delete();
    exp_reads = 0;
    if (x == 0 || y == 0) v = 8'h80;
    else begin v = pix(x - 1, y - 1); exp_reads++; end
    exp_q.push_back({1'b0, 2'd3, v});
    for (int j = 0; j < TR * n; j++) begin
      if (y == 0) v = 8'h80;
      else if (j >= n && x + j >= W) v = top_last;
      else begin v = pix(x + j, y - 1); exp_reads++; end
      if (j == n - 1) top_last = v;
      exp_q.push_back({1'b0, 2'd1, v});
    end
    for (int i = 0; i < n; i++) begin
      if (x == 0) v = 8'h80;
      else begin v = pix(x - 1, y + i); exp_reads++; end
      exp_q.push_back({1'b0, 2'd2, v});
    end
    for (int r = 0; r < n; r++)
      for (int c = 0; c < n; c++) begin
        exp_reads++;
        exp_q.push_back({(r == n - 1) && (c == n - 1), 2'd0, pix(x + c, y + r)});
      end
  endtask

  // Runs one job from a point just after a falling edge; returns just after
  // the falling edge following busy's fall, so a chained call is back-to-back.
  task automatic run_job(input int sz, input int x, input int y, input bit rnd, input bit poke);
    int n, k, cyc, reads, first_v, lim;
    bit done, prev_stall, err_seen;
    logic [10:0] prev_beat, got, want;
    n = (sz == 0) ? 4 : (sz == 1) ? 8 : 16;
    build_expected(n, x, y);
    lim = (x == 0 || y == 0) ? 2 : 3;
    start = 1'b1; blk_size = 2'(sz); blk_x = 16'(x); blk_y = 16'(y);
    o_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    k = 0; cyc = 0; reads = 0; first_v = -1; done = 0; prev_stall = 0; err_seen = 0;
    prev_beat = '0;
    while (!done && cyc < 3000) begin
      @(negedge clk);
      start = poke && (cyc == 5);
      if (start) blk_size = 2'd3;
      o_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      cyc++;
      if (err) err_seen = 1;
      if (mem_rd_en) reads++;
      if (o_valid && first_v < 0) first_v = cyc;
      got = {o_last, o_tag, o_data};
      if (prev_stall) begin
        checks++;
        if (!o_valid || got !== prev_beat) begin
          failures++;
          $display("FAIL hold beat%0d got v=%0b %03h want v=1 %03h", k, o_valid, got, prev_beat);
        end
      end
      if (o_valid && o_ready) begin
        want = (k < exp_q.size()) ? exp_q[k] : 11'h7ff;
        checks++;
        if (got !== want) begin
          failures++;
          $display("FAIL beat%0d n=%0d (%0d,%0d) got last=%0b tag=%0d data=%02h want last=%0b tag=%0d data=%02h",
                   k, n, x, y, got[10], got[9:8], got[7:0], want[10], want[9:8], want[7:0]);
        end
        if (o_last) done = 1;
        k++;
      end
      prev_stall = o_valid && !o_ready;
      prev_beat  = got;
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL timeout n=%0d (%0d,%0d) beats got %0d want %0d", n, x, y, k, exp_q.size());
    end
    @(negedge clk);
    start = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || k != exp_q.size()) begin
      failures++;
      $display("FAIL end n=%0d busy got %0b want 0, beats got %0d want %0d", n, busy, k, exp_q.size());
    end
    checks++;
    if (reads != exp_reads) begin
      failures++;
      $display("FAIL reads n=%0d (%0d,%0d) got %0d want %0d", n, x, y, reads, exp_reads);
    end
    checks++;
    if (first_v < 1 || first_v > lim || err_seen) begin
      failures++;
      $display("FAIL latency/err n=%0d first_valid got %0d want <=%0d, err_seen=%0b", n, first_v, lim, err_seen);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; blk_size = '0; blk_x = '0; blk_y = '0; o_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    checks++;
    if ({busy, err, mem_rd_en, o_valid, o_last} !== 5'b0) begin
      failures++;
      $display("FAIL reset_ctrl got %05b want 00000", {busy, err, mem_rd_en, o_valid, o_last});
    end
    checks++;
    if ({o_tag, o_data, mem_rd_addr} !== '0) begin
      failures++;
      $display("FAIL reset_data got tag=%0d data=%02h addr=%04h want 0", o_tag, o_data, mem_rd_addr);
    end
    reset = 1'b0;
    @(negedge clk); #1;
  endtask

  task automatic test_corner_origin;
    fill_mem(1);
    run_job(0, 0, 0, 0, 0);
  endtask

  task automatic test_8x8_addr;
    fill_mem(0);
    run_job(1, 8, 8, 0, 0);
  endtask

  task automatic test_right_edge;
    fill_mem(1);
    run_job(2, 240, 16, 0, 0);
  endtask

  task automatic test_random_ready;
    fill_mem(1);
    run_job(2, 32, 32, 1, 1);
  endtask

  task automatic test_back_to_back;
    run_job(0, 252, 0, 1, 0);
    run_job(1, 0, 248, 0, 0);
    run_job(0, 124, 60, 1, 0);
  endtask

  task automatic test_err;
    int sz_t [4] = '{3, 0, 0, 1};
    int x_t  [4] = '{0, 6, 256, 8};
    int y_t  [4] = '{0, 0, 0, 12};
    bit bad;
    for (int t = 0; t < 4; t++) begin
      start = 1'b1; blk_size = 2'(sz_t[t]); blk_x = 16'(x_t[t]); blk_y = 16'(y_t[t]);
      @(negedge clk); start = 1'b0; #1;
      checks++;
      if ({err, busy} !== 2'b10) begin
        failures++;
        $display("FAIL err_pulse case%0d got err=%0b busy=%0b want err=1 busy=0", t, err, busy);
      end
      @(negedge clk); #1;
      checks++;
      if (err !== 1'b0) begin
        failures++;
        $display("FAIL err_width case%0d got %0b want 0", t, err);
      end
      bad = 0;
      repeat (4) begin
        @(negedge clk); #1;
        if (busy || mem_rd_en || o_valid) bad = 1;
      end
      checks++;
      if (bad) begin
        failures++;
        $display("FAIL err_quiet case%0d activity got 1 want 0", t);
      end
    end
  endtask

  task automatic test_midreset;
    int hs, cyc;
    bit bad;
    fill_mem(0);
    start = 1'b1; blk_size = 2'd1; blk_x = 16'd8; blk_y = 16'd8; o_ready = 1'b1;
    hs = 0; cyc = 0;
    while (hs < 10 && cyc < 500) begin
      @(negedge clk); start = 1'b0; #1;
      cyc++;
      if (o_valid && o_ready) hs++;
    end
    checks++;
    if (hs < 10) begin
      failures++;
      $display("FAIL midreset_reach handshakes got %0d want 10", hs);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    checks++;
    if ({busy, err, mem_rd_en, o_valid, o_last, o_tag, o_data, mem_rd_addr} !== '0) begin
      failures++;
      $display("FAIL midreset_out got busy=%0b v=%0b rd=%0b data=%02h addr=%04h want 0",
               busy, o_valid, mem_rd_en, o_data, mem_rd_addr);
    end
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    bad = 0;
    repeat (10) begin
      @(negedge clk); #1;
      if (busy || mem_rd_en || o_valid) bad = 1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL midreset_quiet activity got 1 want 0");
    end
    run_job(1, 8, 8, 0, 0);
  endtask

  task automatic test_random_jobs;
    int sz, n, x, y;
    fill_mem(1);
    for (int i = 0; i < 4; i++) begin
      sz = $urandom_range(0, 2);
      n  = (sz == 0) ? 4 : (sz == 1) ? 8 : 16;
      x  = (i % 2 == 0) ? W - n : $urandom_range(0, W / n - 1) * n;
      y  = $urandom_range(0, H / n - 1) * n;
      run_job(sz, x, y, 1, i == 1);
    end
  endtask

  initial begin
    test_reset();
    test_corner_origin();
    test_8x8_addr();
    test_right_edge();
    test_random_ready();
    test_back_to_back();
    test_err();
    test_midreset();
    test_random_jobs();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
